// File: rtl/avr_seq_pkg.sv
// Shared constants for the AVR-side SRAM burst sequencer: one-hot state codes,
// default widths and the idle level of every cartridge control pin.
package avr_seq_pkg;

  localparam int DEF_ADDR_W        = 24;
  localparam int DEF_LEN_W         = 8;
  localparam int DEF_STROBE_CYCLES = 2;

  localparam int ST_W = 7;
  localparam logic [ST_W-1:0] ST_IDLE    = 7'b000_0001;
  localparam logic [ST_W-1:0] ST_SHIFT   = 7'b000_0010;
  localparam logic [ST_W-1:0] ST_LATCH   = 7'b000_0100;
  localparam logic [ST_W-1:0] ST_STROBE  = 7'b000_1000;
  localparam logic [ST_W-1:0] ST_RECOVER = 7'b001_0000;
  localparam logic [ST_W-1:0] ST_INC     = 7'b010_0000;
  localparam logic [ST_W-1:0] ST_DONE    = 7'b100_0000;

  typedef enum logic [ST_W-1:0] {
    S_IDLE    = ST_IDLE,
    S_SHIFT   = ST_SHIFT,
    S_LATCH   = ST_LATCH,
    S_STROBE  = ST_STROBE,
    S_RECOVER = ST_RECOVER,
    S_INC     = ST_INC,
    S_DONE    = ST_DONE
  } state_t;

  localparam logic SI_IDLE        = 1'b0;
  localparam logic SREG_EN_N_IDLE = 1'b1;
  localparam logic OE_N_IDLE      = 1'b1;
  localparam logic WE_N_IDLE      = 1'b1;
  localparam logic COUNTER_N_IDLE = 1'b1;
  localparam logic SNES_MODE_IDLE = 1'b0;

endpackage

// File: rtl/avr_addr_shifter.sv
// Serialises a start address MSB first onto si with sreg_en_n low for ADDR_W cycles.
// Starts on the load edge; last flags the final bit so the caller can leave SHIFT.
module avr_addr_shifter
  import avr_seq_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              avr_clk,
  input  logic              avr_reset_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  output logic              si,
  output logic              sreg_en_n,
  output logic              last
);

  localparam int CW = $clog2(ADDR_W);

  logic [ADDR_W-1:0] shreg;
  logic [CW-1:0]     bit_cnt;

  always_ff @(posedge avr_clk) begin
    if (!avr_reset_n) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      si        <= SI_IDLE;
      sreg_en_n <= SREG_EN_N_IDLE;
    end else if (load) begin
      // MSB goes straight to the pin; the rest waits left-aligned in shreg
      si        <= load_addr[ADDR_W-1];
      shreg     <= {load_addr[ADDR_W-2:0], 1'b0};
      bit_cnt   <= CW'(ADDR_W - 1);
      sreg_en_n <= 1'b0;
    end else if (!sreg_en_n) begin
      if (last) begin
        si        <= SI_IDLE;
        sreg_en_n <= SREG_EN_N_IDLE;
      end else begin
        si      <= shreg[ADDR_W-1];
        shreg   <= {shreg[ADDR_W-2:0], 1'b0};
        bit_cnt <= bit_cnt - CW'(1);
      end
    end
  end

  assign last = !sreg_en_n && (bit_cnt == '0);

endmodule

// File: rtl/avr_sram_sequencer.sv
// One SRAM burst from the AVR: shift address, then oe_n/we_n strobe per word; done after
// ADDR_W+STROBE_CYCLES+3+len*(STROBE_CYCLES+2) cycles; busy blocks cmd. AVR_SEQ_SNES_HANDOFF_EN adds SNES handoff.
module avr_sram_sequencer
  import avr_seq_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int LEN_W         = DEF_LEN_W,
  parameter int STROBE_CYCLES = DEF_STROBE_CYCLES
) (
  input  logic              avr_clk,
  input  logic              avr_reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              snes_mode_req,
  output logic              avr_si,
  output logic              avr_sreg_en_n,
  output logic              avr_oe_n,
  output logic              avr_we_n,
  output logic              avr_counter_n,
  output logic              avr_snes_mode,
  output logic              data_strobe,
  output logic              busy,
  output logic              done
);

  localparam int TW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam logic [TW-1:0] STROBE_LAST = TW'(STROBE_CYCLES - 1);

  state_t           state;
  logic             wr;
  logic [LEN_W-1:0] words_left;
  logic [TW-1:0]    timer;
  logic             accept;
  logic             shift_last;

  assign cmd_ready = (state == S_IDLE) && !avr_snes_mode && avr_reset_n;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != S_IDLE);

  avr_addr_shifter #(.ADDR_W(ADDR_W)) u_shifter (
    .avr_clk     (avr_clk),
    .avr_reset_n (avr_reset_n),
    .load        (accept),
    .load_addr   (cmd_addr),
    .si          (avr_si),
    .sreg_en_n   (avr_sreg_en_n),
    .last        (shift_last)
  );

  always_ff @(posedge avr_clk) begin
    if (!avr_reset_n) begin
      state         <= S_IDLE;
      wr            <= 1'b0;
      words_left    <= '0;
      timer         <= '0;
      avr_oe_n      <= OE_N_IDLE;
      avr_we_n      <= WE_N_IDLE;
      avr_counter_n <= COUNTER_N_IDLE;
      data_strobe   <= 1'b0;
      done          <= 1'b0;
    end else begin
      done          <= 1'b0;
      data_strobe   <= 1'b0;
      avr_counter_n <= COUNTER_N_IDLE;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state      <= S_SHIFT;
            wr         <= cmd_write;
            words_left <= cmd_len;
          end
        end
        S_SHIFT: begin
          if (shift_last) state <= S_LATCH;
        end
        S_LATCH, S_INC: begin
          // Word count drops as we leave INC so all-ones length yields 2^LEN_W words
          if (state == S_INC) words_left <= words_left - LEN_W'(1);
          state       <= S_STROBE;
          timer       <= STROBE_LAST;
          avr_oe_n    <= wr;
          avr_we_n    <= ~wr;
          data_strobe <= (STROBE_CYCLES == 1);
        end
        S_STROBE: begin
          if (timer == '0) begin
            state    <= S_RECOVER;
            avr_oe_n <= OE_N_IDLE;
            avr_we_n <= WE_N_IDLE;
          end else begin
            timer       <= timer - TW'(1);
            data_strobe <= (timer == TW'(1));
          end
        end
        S_RECOVER: begin
          if (words_left != '0) begin
            state         <= S_INC;
            avr_counter_n <= 1'b0;
          end else begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef AVR_SEQ_SNES_HANDOFF_EN
  logic snes_mode;

  // A new command in the same IDLE cycle wins; a request seen mid-burst lands after DONE
  always_ff @(posedge avr_clk) begin
    if (!avr_reset_n) begin
      snes_mode <= SNES_MODE_IDLE;
    end else if (!snes_mode_req) begin
      snes_mode <= 1'b0;
    end else if ((state == S_IDLE && !accept) || state == S_DONE) begin
      snes_mode <= 1'b1;
    end
  end

  assign avr_snes_mode = snes_mode;
`else
  logic unused_snes_req;
  assign unused_snes_req = snes_mode_req;
  assign avr_snes_mode   = SNES_MODE_IDLE;
`endif

endmodule

// File: tb/tb_avr_sram_sequencer.sv
// Directed and random bursts checked cycle by cycle against an arithmetic pin-timeline model.
module tb_avr_sram_sequencer;

  localparam int AW = 24;
  localparam int LW = 8;
  localparam int SC = 2;

  logic          avr_clk;
  logic          avr_reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          snes_mode_req;
  logic          avr_si, avr_sreg_en_n, avr_oe_n, avr_we_n, avr_counter_n, avr_snes_mode;
  logic          data_strobe, busy, done;

  int vectors;
  int miscompares;

  logic          b_w;
  logic [AW-1:0] b_a;
  int            b_l;

  avr_sram_sequencer #(.ADDR_W(AW), .LEN_W(LW), .STROBE_CYCLES(SC)) dut (
    .avr_clk       (avr_clk),
    .avr_reset_n   (avr_reset_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_len       (cmd_len),
    .snes_mode_req (snes_mode_req),
    .avr_si        (avr_si),
    .avr_sreg_en_n (avr_sreg_en_n),
    .avr_oe_n      (avr_oe_n),
    .avr_we_n      (avr_we_n),
    .avr_counter_n (avr_counter_n),
    .avr_snes_mode (avr_snes_mode),
    .data_strobe   (data_strobe),
    .busy          (busy),
    .done          (done)
  );

  initial begin
    avr_clk = 1'b0;
    forever #5 avr_clk = ~avr_clk;
  end

  // {cmd_ready, busy, done, data_strobe, counter_n, we_n, oe_n, sreg_en_n, si, snes_mode}
  logic [9:0] act;
  assign act = {cmd_ready, busy, done, data_strobe, avr_counter_n,
                avr_we_n, avr_oe_n, avr_sreg_en_n, avr_si, avr_snes_mode};

  localparam logic [9:0] IDLE_RDY   = 10'b10_0011_1100;
  localparam logic [9:0] IDLE_NORDY = 10'b00_0011_1100;
  localparam logic [9:0] IDLE_SNES  = 10'b00_0011_1101;

  function automatic int done_cycle(input int l);
    return AW + SC + 3 + l * (SC + 2);
  endfunction

  // Expected pins in cycle n after the accept edge (n=1 is the first address bit)
  function automatic logic [9:0] exp_vec(input int n, input logic w, input logic [AW-1:0] a, input int l);
    logic si, sen, oe, we, cn, ds, dn, bz;
    int   nd, k, word, ph;
    si = 1'b0; sen = 1'b1; oe = 1'b1; we = 1'b1; cn = 1'b1; ds = 1'b0;
    nd = done_cycle(l);
    bz = (n >= 1 && n <= nd);
    dn = (n == nd);
    if (n >= 1 && n <= AW) begin
      sen = 1'b0;
      si  = a[AW-n];
    end else if (n >= AW + 2 && n <= nd) begin
      k    = n - (AW + 2);
      word = k / (SC + 2);
      ph   = k % (SC + 2);
      if (ph < SC) begin
        if (w) we = 1'b0; else oe = 1'b0;
        ds = (ph == SC - 1);
      end else if (ph == SC + 1 && word < l) begin
        cn = 1'b0;
      end
    end
    return {~bz, bz, dn, ds, cn, we, oe, sen, si, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [AW-1:0] a, input int l);
    @(negedge avr_clk);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = LW'(l);
    chk("accept_ready", {31'b0, cmd_ready}, 32'd1);
  endtask

  // Walks the burst through the cycle after done; optional early stop and second-command injection
  task automatic trace(input string name, input logic w, input logic [AW-1:0] a, input int l,
                       input int stop_at, input int inject_at);
    int nd;
    nd = done_cycle(l);
    for (int n = 1; n <= nd + 1; n++) begin
      @(negedge avr_clk);
      if (n == 1) begin
        cmd_valid = 1'b0;
        cmd_write = ~w;
        cmd_addr  = AW'($urandom);
        cmd_len   = LW'($urandom);
      end
      chk($sformatf("%s_cyc%0d", name, n), {22'b0, act}, {22'b0, exp_vec(n, w, a, l)});
      if (n == inject_at) begin
        cmd_valid = 1'b1;
        cmd_write = b_w;
        cmd_addr  = b_a;
        cmd_len   = LW'(b_l);
      end
      if (n == stop_at) return;
    end
  endtask

  initial begin
    logic          w;
    logic [AW-1:0] a;
    int            l;

    vectors       = 0;
    miscompares   = 0;
    avr_reset_n   = 1'b0;
    cmd_valid     = 1'b1;
    cmd_write     = 1'b1;
    cmd_addr      = AW'($urandom);
    cmd_len       = 8'd3;
    snes_mode_req = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge avr_clk);
      chk($sformatf("reset_hold%0d", i), {22'b0, act}, {22'b0, IDLE_NORDY});
    end
    cmd_valid   = 1'b0;
    avr_reset_n = 1'b1;
    @(negedge avr_clk);
    chk("reset_release", {22'b0, act}, {22'b0, IDLE_RDY});

    issue(1'b0, 24'hA53C01, 0);
    trace("rd_a53c01", 1'b0, 24'hA53C01, 0, 0, 0);

    issue(1'b1, 24'h000010, 3);
    trace("wr_len3", 1'b1, 24'h000010, 3, 0, 0);

    b_w = 1'b1; b_a = AW'($urandom); b_l = 2;
    a = AW'($urandom);
    issue(1'b0, a, 1);
    trace("busy_first", 1'b0, a, 1, 0, 10);
    trace("busy_second", b_w, b_a, b_l, 0, 0);

    a = AW'($urandom);
    issue(1'b1, a, 2);
    trace("abort", 1'b1, a, 2, AW + 2, 0);
    avr_reset_n = 1'b0;
    @(negedge avr_clk);
    chk("abort_edge", {22'b0, act}, {22'b0, IDLE_NORDY});
    avr_reset_n = 1'b1;
    @(negedge avr_clk);
    chk("abort_idle", {22'b0, act}, {22'b0, IDLE_RDY});
    a = AW'($urandom);
    issue(1'b1, a, 1);
    trace("post_abort", 1'b1, a, 1, 0, 0);

    for (int r = 0; r < 6; r++) begin
      w = 1'($urandom);
      a = AW'($urandom);
      l = $urandom_range(0, 5);
`ifndef AVR_SEQ_SNES_HANDOFF_EN
      snes_mode_req = 1'($urandom);
`endif
      issue(w, a, l);
      trace($sformatf("rand%0d", r), w, a, l, 0, 0);
    end
    snes_mode_req = 1'b0;

    a = AW'($urandom);
    issue(1'b1, a, 255);
    trace("len_max", 1'b1, a, 255, 0, 0);

`ifdef AVR_SEQ_SNES_HANDOFF_EN
    a = AW'($urandom);
    issue(1'b0, a, 1);
    snes_mode_req = 1'b1;
    trace("handoff", 1'b0, a, 1, done_cycle(1), 0);
    @(negedge avr_clk);
    chk("handoff_set", {22'b0, act}, {22'b0, IDLE_SNES});
    @(negedge avr_clk);
    chk("handoff_hold", {22'b0, act}, {22'b0, IDLE_SNES});
    snes_mode_req = 1'b0;
    @(negedge avr_clk);
    chk("handoff_clear", {22'b0, act}, {22'b0, IDLE_RDY});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
